ext_int_plic: RTL and testbench

Parametrised successor to the external interrupt controller on the XT bus. It gathers `INT_NUM` peripheral interrupt lines, each configurable as level- or edge-triggered with its own priority. A registered priority arbiter with threshold masking drives the core's machine external interrupt. A claim/complete handshake ensures each source is serviced exactly once per request. It sits between the peripheral IRQ lines and the RISC-V core's `mextern_int`/`mextern_int_id` inputs.

---
 rtl/xt_int_pkg.sv | 35 +++
 rtl/int_prio_arbiter.sv | 59 +++++
 rtl/ext_int_plic.sv | 162 ++++++++++++++++
 tb/tb_ext_int_plic.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xt_int_pkg.sv
`default_nettype none
// ============================================================================
// Package  : xt_int_pkg
// Purpose  : Shared types and register offsets for the XT-bus external
//            interrupt controller (ext_int_plic).
// Revision : 1.0 - initial parametrised release
// ============================================================================
package xt_int_pkg;

   // Default offset added to the winning source index on mextern_int_id
   localparam int ID_BASE_DEFAULT = 16;

   // Register byte offsets; the controller decodes addr[7:2]
   localparam logic [7:0] OFF_ENABLE    = 8'h00;
   localparam logic [7:0] OFF_PENDING   = 8'h04;
   localparam logic [7:0] OFF_MODE      = 8'h08;
   localparam logic [7:0] OFF_THRESHOLD = 8'h0C;
   localparam logic [7:0] OFF_CLAIM     = 8'h10;
   localparam logic [7:0] OFF_PRIORITY  = 8'h40;

   // XT bus request as seen by a slave
   typedef struct packed {
      logic [31:0] waddr;
      logic [31:0] wdata;
      logic [31:0] raddr;
   } hb_slave_t;

   // Per-slave access strobes
   typedef struct packed {
      logic wen;
      logic ren;
   } sel_t;

endpackage
`default_nettype wire

// File: rtl/int_prio_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : int_prio_arbiter
// Purpose  : Combinational priority arbiter. Picks the eligible source with
//            the highest priority; ties resolve to the lower index.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module int_prio_arbiter #(
   parameter  int INT_NUM   = 32,
   parameter  int PRIO_BITS = 3,
   localparam int IDX_W     = (INT_NUM > 1) ? $clog2(INT_NUM) : 1
) (
   input  logic [INT_NUM-1:0]                eligible,
   input  logic [INT_NUM-1:0][PRIO_BITS-1:0] prios,
   output logic                              valid,
   output logic [IDX_W-1:0]                  idx,
   output logic [PRIO_BITS-1:0]              prio
);

   // Heap-ordered binary tree: node n has children 2n+1 (lower indices)
   // and 2n+2 (higher indices); leaves padded to a power of two.
   localparam int LEAVES = 1 << $clog2(INT_NUM);
   localparam int NODES  = 2 * LEAVES - 1;

   logic                 n_valid [NODES];
   logic [IDX_W-1:0]     n_idx   [NODES];
   logic [PRIO_BITS-1:0] n_prio  [NODES];

   // Reduce leaves to root; the left child wins on equal priority
   always_comb begin
      for (int n = 0; n < NODES; n++) begin
         n_valid[n] = 1'b0;
         n_idx[n]   = '0;
         n_prio[n]  = '0;
      end
      for (int i = 0; i < INT_NUM; i++) begin
         n_valid[LEAVES-1+i] = eligible[i];
         n_idx[LEAVES-1+i]   = IDX_W'(i);
         n_prio[LEAVES-1+i]  = prios[i];
      end
      for (int n = LEAVES - 2; n >= 0; n--) begin
         if (n_valid[2*n+1] && (!n_valid[2*n+2] || (n_prio[2*n+1] >= n_prio[2*n+2]))) begin
            n_valid[n] = n_valid[2*n+1];
            n_idx[n]   = n_idx[2*n+1];
            n_prio[n]  = n_prio[2*n+1];
         end else begin
            n_valid[n] = n_valid[2*n+2];
            n_idx[n]   = n_idx[2*n+2];
            n_prio[n]  = n_prio[2*n+2];
         end
      end
   end

   assign valid = n_valid[0];
   assign idx   = n_idx[0];
   assign prio  = n_prio[0];

endmodule
`default_nettype wire

// File: rtl/ext_int_plic.sv
`default_nettype none
// ============================================================================
// Module   : ext_int_plic
// Purpose  : External interrupt controller on the XT bus. Level/edge
//            gateways, threshold-masked priority arbitration and a
//            claim/complete handshake driving the core's machine external
//            interrupt.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module ext_int_plic
   import xt_int_pkg::*;
#(
   parameter int INT_NUM   = 32,
   parameter int PRIO_BITS = 3,
   parameter int ID_BASE   = ID_BASE_DEFAULT
) (
   input  logic               hb_clk,
   input  logic               rst_n,
   input  hb_slave_t          xt_hb,
   input  sel_t               sel,
   output logic [31:0]        rdata,
   input  logic [INT_NUM-1:0] irq_source,
   output logic [30:0]        mextern_int_id,
   output logic               mextern_int
);

   localparam int IDX_W = (INT_NUM > 1) ? $clog2(INT_NUM) : 1;
   typedef logic [PRIO_BITS-1:0] int_prio_t;

   localparam logic [5:0] W_ENABLE  = OFF_ENABLE[7:2];
   localparam logic [5:0] W_PENDING = OFF_PENDING[7:2];
   localparam logic [5:0] W_MODE    = OFF_MODE[7:2];
   localparam logic [5:0] W_THRESH  = OFF_THRESHOLD[7:2];
   localparam logic [5:0] W_CLAIM   = OFF_CLAIM[7:2];
   localparam logic [5:0] W_PRIO    = OFF_PRIORITY[7:2];
   localparam logic [6:0] NUM7      = 7'(INT_NUM);

   logic [INT_NUM-1:0] enable, mode, pending, in_service, irq_q;
   int_prio_t          threshold;
   int_prio_t          prio [INT_NUM];
   logic               best_valid;
   logic [IDX_W-1:0]   best_idx;

   logic [INT_NUM-1:0] edge_set, claim_vec, complete_vec, w1c_vec, pending_nxt, eligible;
   logic [INT_NUM-1:0][PRIO_BITS-1:0] prio_vec;
   logic               arb_valid;
   logic [IDX_W-1:0]   arb_idx;
   int_prio_t          arb_prio;
   logic [31:0]        rd_val, claim_id;

   // Bus decode
   logic [5:0] wword, rword, wpidx, rpidx;
   logic       wr_enable, wr_pending, wr_mode, wr_thresh, wr_claim, claim_hit;
   logic       wr_prio_range, rd_prio_range;
   logic       unused_addr_bits;

   assign wword         = xt_hb.waddr[7:2];
   assign rword         = xt_hb.raddr[7:2];
   assign wpidx         = wword - W_PRIO;
   assign rpidx         = rword - W_PRIO;
   assign wr_enable     = sel.wen && (wword == W_ENABLE);
   assign wr_pending    = sel.wen && (wword == W_PENDING);
   assign wr_mode       = sel.wen && (wword == W_MODE);
   assign wr_thresh     = sel.wen && (wword == W_THRESH);
   assign wr_claim      = sel.wen && (wword == W_CLAIM);
   assign claim_hit     = sel.ren && (rword == W_CLAIM) && best_valid;
   assign wr_prio_range = sel.wen && (wword >= W_PRIO) && ({1'b0, wpidx} < NUM7);
   assign rd_prio_range = (rword >= W_PRIO) && ({1'b0, rpidx} < NUM7);
   assign unused_addr_bits = ^{xt_hb.waddr[31:8], xt_hb.waddr[1:0],
                               xt_hb.raddr[31:8], xt_hb.raddr[1:0]};

   // Per-source gateway: edge/level capture, claim and W1C clearing
   for (genvar i = 0; i < INT_NUM; i++) begin : g_source
      assign edge_set[i]     = irq_source[i] & ~irq_q[i];
      assign claim_vec[i]    = claim_hit && (best_idx == IDX_W'(i));
      assign complete_vec[i] = wr_claim && (xt_hb.wdata == 32'(i + 1));
      assign w1c_vec[i]      = wr_pending & xt_hb.wdata[i];
      // A fresh edge beats any clear in the same cycle; level sources are
      // masked while in service so they cannot re-fire until completed.
      assign pending_nxt[i]  = mode[i]
                             ? (edge_set[i] | (pending[i] & ~(claim_vec[i] | w1c_vec[i])))
                             : (irq_source[i] & ~in_service[i]);
      assign eligible[i]     = pending[i] & enable[i] & ~in_service[i] & (prio[i] > threshold);
      assign prio_vec[i]     = prio[i];
   end

   int_prio_arbiter #(
      .INT_NUM   (INT_NUM),
      .PRIO_BITS (PRIO_BITS)
   ) u_arbiter (
      .eligible (eligible),
      .prios    (prio_vec),
      .valid    (arb_valid),
      .idx      (arb_idx),
      .prio     (arb_prio)
   );

   assign claim_id = {{(32-IDX_W){1'b0}}, best_idx} + 32'd1;

   // Read data mux; unmapped offsets return 0
   always_comb begin
      rd_val = '0;
      case (rword)
         W_ENABLE:  rd_val[INT_NUM-1:0]   = enable;
         W_PENDING: rd_val[INT_NUM-1:0]   = pending;
         W_MODE:    rd_val[INT_NUM-1:0]   = mode;
         W_THRESH:  rd_val[PRIO_BITS-1:0] = threshold;
         W_CLAIM:   if (best_valid) rd_val = claim_id;
         default: begin
            for (int i = 0; i < INT_NUM; i++)
               if (rd_prio_range && (rpidx == 6'(i))) rd_val[PRIO_BITS-1:0] = prio[i];
         end
      endcase
   end

   // Software-visible configuration registers
   always_ff @(posedge hb_clk or negedge rst_n) begin
      if (!rst_n) begin
         enable    <= '0;
         mode      <= '0;
         threshold <= '0;
         for (int i = 0; i < INT_NUM; i++) prio[i] <= int_prio_t'(1);
      end else begin
         if (wr_enable) enable    <= xt_hb.wdata[INT_NUM-1:0];
         if (wr_mode)   mode      <= xt_hb.wdata[INT_NUM-1:0];
         if (wr_thresh) threshold <= xt_hb.wdata[PRIO_BITS-1:0];
         for (int i = 0; i < INT_NUM; i++)
            if (wr_prio_range && (wpidx == 6'(i))) prio[i] <= xt_hb.wdata[PRIO_BITS-1:0];
      end
   end

   // Source capture and claim/complete state; complete overrides claim
   always_ff @(posedge hb_clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_q      <= '0;
         pending    <= '0;
         in_service <= '0;
      end else begin
         irq_q      <= irq_source;
         pending    <= pending_nxt;
         in_service <= (in_service | claim_vec) & ~complete_vec;
      end
   end

   // Registered arbiter result and registered read data
   always_ff @(posedge hb_clk or negedge rst_n) begin
      if (!rst_n) begin
         best_valid <= 1'b0;
         best_idx   <= '0;
         rdata      <= '0;
      end else begin
         best_valid <= arb_valid && (arb_prio > threshold);
         best_idx   <= arb_idx;
         if (sel.ren) rdata <= rd_val;
      end
   end

   assign mextern_int    = best_valid;
   assign mextern_int_id = 31'(ID_BASE) + {{(31-IDX_W){1'b0}}, best_idx};

endmodule
`default_nettype wire

// File: tb/tb_ext_int_plic.sv
`default_nettype none
// ============================================================================
// Module   : tb_ext_int_plic
// Purpose  : Self-checking bench for ext_int_plic: directed scenarios plus a
//            randomized level-mode phase against a settled-state model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ext_int_plic;
   import xt_int_pkg::*;

   localparam int N = 32;

   logic        hb_clk = 1'b0;
   logic        rst_n;
   hb_slave_t   xt_hb;
   sel_t        sel;
   logic [31:0] rdata;
   logic [N-1:0] irq_source;
   logic [30:0] mextern_int_id;
   logic        mextern_int;

   int total  = 0;
   int passed = 0;

   // Reference model state (settled, level-mode view)
   int unsigned  mp [N];
   logic [N-1:0] m_en, m_svc, m_src;
   int unsigned  m_th;

   ext_int_plic #(.INT_NUM(N), .PRIO_BITS(3), .ID_BASE(16)) dut (
      .hb_clk         (hb_clk),
      .rst_n          (rst_n),
      .xt_hb          (xt_hb),
      .sel            (sel),
      .rdata          (rdata),
      .irq_source     (irq_source),
      .mextern_int_id (mextern_int_id),
      .mextern_int    (mextern_int)
   );

   always #5 hb_clk = ~hb_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge hb_clk);
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      @(negedge hb_clk);
      xt_hb.waddr = {24'h0, a};
      xt_hb.wdata = d;
      sel.wen     = 1'b1;
      @(negedge hb_clk);
      sel.wen     = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] d);
      @(negedge hb_clk);
      xt_hb.raddr = {24'h0, a};
      sel.ren     = 1'b1;
      @(negedge hb_clk);
      sel.ren     = 1'b0;
      d           = rdata;
   endtask

   // Highest priority eligible source, lowest index on ties; -1 if none
   function automatic int model_winner();
      int best = -1;
      for (int i = 0; i < N; i++)
         if (m_src[i] && m_en[i] && !m_svc[i] && (mp[i] > m_th))
            if (best < 0 || mp[i] > mp[best]) best = i;
      return best;
   endfunction

   initial begin
      logic [31:0] d;
      int          w;
      int          v;
      xt_hb      = '0;
      sel        = '0;
      irq_source = '0;
      rst_n      = 1'b0;
      cyc(2);
      chk("rst_int", {31'h0, mextern_int}, 32'h0);
      chk("rst_id", {1'b0, mextern_int_id}, 32'd16);
      chk("rst_rdata", rdata, 32'h0);
      rst_n = 1'b1;
      cyc(1);

      // Reset register contents
      rd(8'h00, d); chk("rst_enable", d, 32'h0);
      rd(8'h04, d); chk("rst_pending", d, 32'h0);
      rd(8'h08, d); chk("rst_mode", d, 32'h0);
      rd(8'h0C, d); chk("rst_thresh", d, 32'h0);
      rd(8'h10, d); chk("rst_claim", d, 32'h0);
      rd(8'h20, d); chk("unmapped_rd", d, 32'h0);
      for (int i = 0; i < N; i++) begin
         rd(8'h40 + 8'(4 * i), d);
         chk("rst_prio", d, 32'd1);
      end
      wr(8'h24, 32'hFFFF_FFFF);
      rd(8'h00, d); chk("unmapped_wr", d, 32'h0);

      // Level source 3
      wr(8'h00, 32'h8);
      irq_source = 32'h8;
      cyc(1); chk("lvl_lat1", {31'h0, mextern_int}, 32'h0);
      cyc(1); chk("lvl_lat2", {31'h0, mextern_int}, 32'h1);
      chk("lvl_id", {1'b0, mextern_int_id}, 32'd19);
      rd(8'h10, d); chk("lvl_claim", d, 32'd4);
      cyc(1); chk("lvl_drop", {31'h0, mextern_int}, 32'h0);
      wr(8'h10, 32'd4);
      cyc(1); chk("lvl_cmp1", {31'h0, mextern_int}, 32'h0);
      cyc(1); chk("lvl_cmp2", {31'h0, mextern_int}, 32'h1);
      chk("lvl_cmp_id", {1'b0, mextern_int_id}, 32'd19);
      irq_source = '0;
      wr(8'h00, 32'h0);
      cyc(3);

      // Priority and threshold with sources 2 and 5
      wr(8'h48, 32'd2);
      wr(8'h54, 32'd6);
      wr(8'h00, 32'h24);
      irq_source = 32'h24;
      cyc(3);
      chk("pr_int", {31'h0, mextern_int}, 32'h1);
      chk("pr_id", {1'b0, mextern_int_id}, 32'd21);
      wr(8'h0C, 32'd6); cyc(2);
      chk("th6_int", {31'h0, mextern_int}, 32'h0);
      wr(8'h0C, 32'd1); cyc(2);
      chk("th1_int", {31'h0, mextern_int}, 32'h1);
      chk("th1_id", {1'b0, mextern_int_id}, 32'd21);
      irq_source = '0;
      wr(8'h0C, 32'd0);
      wr(8'h00, 32'h0);
      cyc(3);

      // Edge source 7
      wr(8'h08, 32'h80);
      wr(8'h00, 32'h80);
      @(negedge hb_clk); irq_source = 32'h80;
      @(negedge hb_clk); irq_source = 32'h0;
      cyc(1);
      chk("edge_int", {31'h0, mextern_int}, 32'h1);
      chk("edge_id", {1'b0, mextern_int_id}, 32'd23);
      rd(8'h04, d); chk("edge_pend", d, 32'h80);
      rd(8'h10, d); chk("edge_claim", d, 32'd8);
      cyc(1); chk("edge_drop", {31'h0, mextern_int}, 32'h0);
      rd(8'h04, d); chk("edge_pend_clr", d, 32'h0);
      @(negedge hb_clk); irq_source = 32'h80;
      @(negedge hb_clk); irq_source = 32'h0;
      cyc(2);
      rd(8'h04, d); chk("edge_pend_svc", d, 32'h80);
      chk("edge_svc_int", {31'h0, mextern_int}, 32'h0);
      wr(8'h10, 32'd8);
      cyc(1);
      chk("edge_re_int", {31'h0, mextern_int}, 32'h1);
      chk("edge_re_id", {1'b0, mextern_int_id}, 32'd23);
      wr(8'h04, 32'h80);
      cyc(1);
      chk("w1c_int", {31'h0, mextern_int}, 32'h0);
      rd(8'h04, d); chk("w1c_pend", d, 32'h0);
      wr(8'h08, 32'h0);
      wr(8'h00, 32'h0);

      // Tie between sources 1 and 4, and ignored completes
      wr(8'h44, 32'd3);
      wr(8'h50, 32'd3);
      wr(8'h00, 32'h12);
      irq_source = 32'h12;
      cyc(3);
      chk("tie_id", {1'b0, mextern_int_id}, 32'd17);
      rd(8'h10, d); chk("tie_claim", d, 32'd2);
      cyc(2);
      chk("tie_next_id", {1'b0, mextern_int_id}, 32'd20);
      wr(8'h10, 32'd0);
      wr(8'h10, 32'd33);
      wr(8'h10, 32'd5);
      cyc(2);
      chk("nocmp_int", {31'h0, mextern_int}, 32'h1);
      chk("nocmp_id", {1'b0, mextern_int_id}, 32'd20);
      rd(8'h04, d); chk("nocmp_pend", d, 32'h10);
      wr(8'h10, 32'd2);
      cyc(3);
      chk("tie_back_id", {1'b0, mextern_int_id}, 32'd17);

      // Randomized level-mode phase against the settled-state model
      m_svc = '0;
      wr(8'h08, 32'h0);
      for (int i = 0; i < N; i++) begin
         mp[i] = $urandom_range(0, 7);
         wr(8'h40 + 8'(4 * i), mp[i]);
      end
      for (int it = 0; it < 40; it++) begin
         m_en  = $urandom | $urandom;
         m_th  = $urandom_range(0, 3);
         m_src = $urandom | $urandom;
         for (int k = 0; k < 4; k++) begin
            w     = $urandom_range(0, N - 1);
            mp[w] = $urandom_range(0, 7);
            wr(8'h40 + 8'(4 * w), mp[w]);
         end
         wr(8'h00, m_en);
         wr(8'h0C, m_th);
         irq_source = m_src;
         cyc(4);
         w = model_winner();
         chk("rnd_int", {31'h0, mextern_int}, (w >= 0) ? 32'h1 : 32'h0);
         if (w >= 0) chk("rnd_id", {1'b0, mextern_int_id}, 32'(16 + w));
         rd(8'h10, d);
         chk("rnd_claim", d, (w >= 0) ? 32'(w + 1) : 32'h0);
         if (w >= 0) m_svc[w] = 1'b1;
         cyc(3);
         w = model_winner();
         chk("rnd_post_int", {31'h0, mextern_int}, (w >= 0) ? 32'h1 : 32'h0);
         v = $urandom_range(0, 34);
         wr(8'h10, 32'(v));
         if (v >= 1 && v <= N) m_svc[v-1] = 1'b0;
         cyc(3);
      end

      // Asynchronous reset while a source is in service
      wr(8'h44, 32'd3);
      wr(8'h50, 32'd3);
      wr(8'h0C, 32'd0);
      wr(8'h00, 32'h12);
      irq_source = 32'h12;
      wr(8'h10, 32'd2);
      wr(8'h10, 32'd5);
      cyc(3);
      rd(8'h10, d); chk("ar_claim", d, 32'd2);
      cyc(2);
      chk("ar_pre_id", {1'b0, mextern_int_id}, 32'd20);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_int", {31'h0, mextern_int}, 32'h0);
      chk("ar_id", {1'b0, mextern_int_id}, 32'd16);
      chk("ar_rdata", rdata, 32'h0);
      @(negedge hb_clk);
      rst_n = 1'b1;
      wr(8'h00, 32'h12);
      cyc(3);
      chk("ar_rearm_int", {31'h0, mextern_int}, 32'h1);
      chk("ar_rearm_id", {1'b0, mextern_int_id}, 32'd17);
      rd(8'h10, d); chk("ar_rearm_claim", d, 32'd2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
